// File: rtl/cordic_pkg.sv
// Shared CORDIC datapath definitions: FSM state encoding, default widths and
// the saturation patterns used by the shifters.
package cordic_pkg;

    localparam int DW_DEFAULT  = 16;
    localparam int SHW_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } lsh_state_t;

    // Patterns are returned in the low dw bits of a 64-bit word, so dw <= 64.
    function automatic logic [63:0] sat_pos(input int dw);
        sat_pos = (64'd1 << (dw - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg(input int dw);
        sat_neg = 64'd1 << (dw - 1);
    endfunction

endpackage

// File: rtl/sat_lsh_seq_if.sv
// Operand/result handshake bundle for the sequential saturating left shifter.
interface sat_lsh_seq_if #(
    parameter int dw  = 16,
    parameter int shw = 4
) ();
    logic           in_valid;
    logic           in_ready;
    logic [shw-1:0] p;
    logic [dw-1:0]  i;
    logic           out_valid;
    logic           out_ready;
    logic [dw-1:0]  o;
    logic           ovf;

    modport master (
        output in_valid, p, i, out_ready,
        input  in_ready, out_valid, o, ovf
    );

    modport slave (
        input  in_valid, p, i, out_ready,
        output in_ready, out_valid, o, ovf
    );
endinterface

// File: rtl/sat_lsh_seq_lsh1_sat.sv
// One saturating left-shift step: shifts by one bit, or clamps to the signed
// extreme when the sign bit is about to be lost.
module lsh1_sat
    import cordic_pkg::*;
#(
    parameter int dw = DW_DEFAULT
) (
    input  logic [dw-1:0] acc,
    output logic [dw-1:0] acc_next,
    output logic          ovf
);

    localparam logic [63:0]   pos_full = sat_pos(dw);
    localparam logic [63:0]   neg_full = sat_neg(dw);
    localparam logic [dw-1:0] pos      = pos_full[dw-1:0];
    localparam logic [dw-1:0] neg      = neg_full[dw-1:0];

    // Top two bits differing means the next shift would flip the sign.
    assign ovf      = acc[dw-1] ^ acc[dw-2];
    assign acc_next = ovf ? (acc[dw-1] ? neg : pos) : {acc[dw-2:0], 1'b0};

endmodule

// File: rtl/sat_lsh_seq.sv
// Sequential saturating arithmetic left shifter: one bit per cycle, stops
// early on signed overflow, valid/ready on both sides.
module sat_lsh_seq
    import cordic_pkg::*;
#(
    parameter int dw  = DW_DEFAULT,
    parameter int shw = SHW_DEFAULT
) (
    input logic         clk,
    input logic         rst,
    sat_lsh_seq_if.slave bus
);

    localparam logic [shw-1:0] one = {{(shw-1){1'b0}}, 1'b1};

    lsh_state_t     state_q, state_d;
    logic [dw-1:0]  acc_q, acc_d;
    logic [shw-1:0] count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [dw-1:0]  step_acc;
    logic           step_ovf;

    lsh1_sat #(.dw(dw)) u_step (
        .acc      (acc_q),
        .acc_next (step_acc),
        .ovf      (step_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_d   = bus.i;
                    count_d = bus.p;
                    ovf_d   = 1'b0;
                    state_d = (bus.p == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_d = step_acc;
                // Saturation ends the operation; the remaining count is dropped.
                if (step_ovf) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    count_d = count_q - one;
                    if (count_q == one) state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.o         = acc_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sat_lsh_seq.sv
// Directed bench for sat_lsh_seq: an arithmetic reference model drives a
// per-cycle compare process, and each scenario also checks literal results.
module tb_sat_lsh_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    sat_lsh_seq_if #(.dw(16), .shw(4)) bus ();

    sat_lsh_seq #(.dw(16), .shw(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                      name, actual, expected, $time);
    endtask

    // Reference: the result is i*2^p clamped to the 16-bit range, and the
    // operation ends at the first shift count whose product leaves that range.
    task automatic model_calc(input logic [15:0] ii, input int pp,
                              output logic [15:0] oo, output logic ov,
                              output int lat);
        longint v;
        longint prod;
        v   = longint'($signed(ii));
        lat = pp;
        ov  = 1'b0;
        for (int j = 1; j <= pp; j++) begin
            prod = v * (longint'(1) << j);
            if (!ov && (prod > 32767 || prod < -32768)) begin
                ov  = 1'b1;
                lat = j;
            end
        end
        prod = v * (longint'(1) << pp);
        if (ov) oo = (v < 0) ? 16'h8000 : 16'h7FFF;
        else    oo = prod[15:0];
    endtask

    logic        m_active = 1'b0;
    int          m_edges  = 0;
    int          m_lat    = 0;
    logic [15:0] m_o      = '0;
    logic        m_ovf    = 1'b0;
    logic [15:0] t_o;
    logic        t_ovf;
    int          t_lat;

    // Model tracks one transaction in flight, independent of the DUT handshake.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_edges  <= 0;
        end else if (!m_active) begin
            if (bus.in_valid) begin
                model_calc(bus.i, int'(bus.p), t_o, t_ovf, t_lat);
                m_o      <= t_o;
                m_ovf    <= t_ovf;
                m_lat    <= t_lat;
                m_edges  <= 0;
                m_active <= 1'b1;
            end
        end else if (m_edges >= m_lat) begin
            if (bus.out_ready) m_active <= 1'b0;
        end else begin
            m_edges <= m_edges + 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
            checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
            checkOutput("rst_o", {16'd0, bus.o}, 32'd0);
        end else if (!m_active) begin
            checkOutput("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
            checkOutput("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end else begin
            checkOutput("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
            checkOutput("out_valid", {31'd0, bus.out_valid},
                        {31'd0, (m_edges >= m_lat)});
            if (m_edges >= m_lat) begin
                checkOutput("model_o", {16'd0, bus.o}, {16'd0, m_o});
                checkOutput("model_ovf", {31'd0, bus.ovf}, {31'd0, m_ovf});
            end
        end
    end

    // Offers one operand, then waits (bounded) for the result and reports
    // how many edges after the accept edge out_valid was first seen.
    task automatic applyStimulus(input logic [15:0] ii, input logic [3:0] pp,
                                 input logic rdy, output int lat);
        @(negedge clk);
        bus.i         = ii;
        bus.p         = pp;
        bus.in_valid  = 1'b1;
        bus.out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.i        = 16'hA5A5;
        bus.p        = 4'hF;
        lat          = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runOne(input string name, input logic [15:0] ii,
                          input logic [3:0] pp, input logic [15:0] exp_o,
                          input logic exp_ovf, input int exp_lat);
        int lat;
        applyStimulus(ii, pp, 1'b1, lat);
        checkOutput({name, "_lat"}, lat, exp_lat);
        checkOutput({name, "_o"}, {16'd0, bus.o}, {16'd0, exp_o});
        checkOutput({name, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
        @(negedge clk);
        checkOutput({name, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.i         = '0;
        bus.p         = '0;

        model_calc(16'h0003, 4, t_o, t_ovf, t_lat);
        checkOutput("pin_model_a", {16'd0, t_o, 7'd0, t_ovf, 8'(t_lat)}, 32'h0030_0004);
        model_calc(16'h9000, 2, t_o, t_ovf, t_lat);
        checkOutput("pin_model_b", {16'd0, t_o, 7'd0, t_ovf, 8'(t_lat)}, 32'h8000_0101);
        model_calc(16'h0001, 15, t_o, t_ovf, t_lat);
        checkOutput("pin_model_c", {16'd0, t_o, 7'd0, t_ovf, 8'(t_lat)}, 32'h7FFF_010F);

        #2 rst = 1'b1;
        #1;
        checkOutput("reset_o", {16'd0, bus.o}, 32'd0);
        checkOutput("reset_ovf", {31'd0, bus.ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        runOne("pos_shift", 16'h0003, 4'd4, 16'h0030, 1'b0, 4);
        runOne("neg_shift", 16'hFFFD, 4'd3, 16'hFFE8, 1'b0, 3);
        runOne("sat_pos", 16'h4000, 4'd1, 16'h7FFF, 1'b1, 1);
        runOne("sat_neg_early", 16'h9000, 4'd2, 16'h8000, 1'b1, 1);
        runOne("full_p15", 16'h0001, 4'd15, 16'h7FFF, 1'b1, 15);
        runOne("zero_op", 16'h0000, 4'd9, 16'h0000, 1'b0, 9);
        runOne("neg_edge", 16'hC000, 4'd1, 16'h8000, 1'b0, 1);

        // Backpressure: result must hold and a new offer must be ignored.
        applyStimulus(16'h1234, 4'd0, 1'b0, lat);
        checkOutput("p0_lat", lat, 0);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = (k % 2 == 0);
            bus.i        = 16'h5555;
            bus.p        = 4'd3;
            @(negedge clk);
            checkOutput("hold_o", {16'd0, bus.o}, 32'h0000_1234);
            checkOutput("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            checkOutput("hold_ovf", {31'd0, bus.ovf}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("hold_release", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of a long shift aborts it.
        @(negedge clk);
        bus.i        = 16'h0001;
        bus.p        = 4'd15;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("abort_o", {16'd0, bus.o}, 32'd0);
        checkOutput("abort_ready", {31'd0, bus.in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("after_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        runOne("after_rst", 16'h0002, 4'd2, 16'h0008, 1'b0, 2);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
